// File: rtl/dcache_pkg.sv
// Shared definitions for the D-cache request-buffer controller:
// FSM state encoding, counter width and the LINE_WORDS legality check.
package dcache_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_WBACK  = 3'd2,
        S_RD_REQ = 3'd3,
        S_REFILL = 3'd4,
        S_UC_WR  = 3'd5,
        S_DONE   = 3'd6
    } state_e;

    localparam int unsigned PERF_W = 32;

    // Line length must be a power of two between 2 and 16 words.
    function automatic bit line_words_ok(input int unsigned n);
        return (n >= 2) && (n <= 16) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/dcache_perf_cnt.sv
// Saturating event counter used for the D-cache hit/miss statistics.
module dcache_perf_cnt
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inc_i,
    output logic [PERF_W-1:0] cnt_o
);

    logic [PERF_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + PERF_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dcache_rbuf_ctrl.sv
// D-cache request-buffer control FSM: capture, lookup, victim writeback,
// refill and uncached access. Hit/miss counters exist only with DCACHE_PERF_EN.
module dcache_rbuf_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic                          req_store_i,
    input  logic                          req_uncached_i,
    input  logic                          flush_i,
    output logic                          rbuf_we_o,
    input  logic                          hit_i,
    input  logic                          victim_dirty_i,
    output logic                          mem_rd_req_o,
    input  logic                          mem_rd_ready_i,
    output logic                          mem_rd_uncached_o,
    input  logic                          mem_ret_valid_i,
    input  logic                          mem_ret_last_i,
    output logic                          mem_wr_req_o,
    input  logic                          mem_wr_ready_i,
    output logic                          refill_we_o,
    output logic [$clog2(LINE_WORDS)-1:0] refill_idx_o,
    output logic                          resp_valid_o,
    output logic                          busy_o,
    output logic [PERF_W-1:0]             perf_hit_o,
    output logic [PERF_W-1:0]             perf_miss_o
);

    localparam int unsigned IDX_W = $clog2(LINE_WORDS);

    generate
        if (!line_words_ok(LINE_WORDS)) begin : g_bad_line_words
            $error("dcache_rbuf_ctrl: LINE_WORDS must be a power of two in 2..16");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               store_q, store_d;
    logic               uc_q, uc_d;

    // The controller keeps its own copy of the request kind so LOOKUP can
    // branch on it; the data half of the request lives in the buffer block.
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        store_d           = store_q;
        uc_d              = uc_q;
        resp_valid_o      = 1'b0;
        mem_rd_req_o      = 1'b0;
        mem_rd_uncached_o = 1'b0;
        mem_wr_req_o      = 1'b0;
        refill_we_o       = 1'b0;

        req_ready_o = !flush_i && ((state_q == S_IDLE) ||
                      ((state_q == S_LOOKUP) && hit_i && !uc_q));
        rbuf_we_o   = req_valid_i && req_ready_o;

        if (rbuf_we_o) begin
            store_d = req_store_i;
            uc_d    = req_uncached_i;
        end

        case (state_q)
            S_IDLE: begin
                if (rbuf_we_o)
                    state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (flush_i)
                    state_d = S_IDLE;
                else if (uc_q)
                    state_d = store_q ? S_UC_WR : S_RD_REQ;
                else if (hit_i) begin
                    resp_valid_o = 1'b1;
                    state_d      = rbuf_we_o ? S_LOOKUP : S_IDLE;
                end else
                    state_d = victim_dirty_i ? S_WBACK : S_RD_REQ;
            end
            S_WBACK: begin
                mem_wr_req_o = 1'b1;
                if (mem_wr_ready_i)
                    state_d = S_RD_REQ;
            end
            S_UC_WR: begin
                mem_wr_req_o = 1'b1;
                if (mem_wr_ready_i)
                    state_d = S_DONE;
            end
            S_RD_REQ: begin
                mem_rd_req_o      = 1'b1;
                mem_rd_uncached_o = uc_q;
                cnt_d             = '0;
                if (mem_rd_ready_i)
                    state_d = S_REFILL;
            end
            S_REFILL: begin
                // Beat index wraps naturally at LINE_WORDS (power of two).
                if (mem_ret_valid_i) begin
                    refill_we_o = !uc_q;
                    cnt_d       = cnt_q + IDX_W'(1);
                    if (mem_ret_last_i)
                        state_d = S_DONE;
                end
            end
            S_DONE: begin
                resp_valid_o = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            store_q <= 1'b0;
            uc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            store_q <= store_d;
            uc_q    <= uc_d;
        end
    end

    assign refill_idx_o = cnt_q;
    assign busy_o       = (state_q != S_IDLE);

`ifdef DCACHE_PERF_EN
    logic lookup_cached;
    logic hit_inc, miss_inc;

    assign lookup_cached = (state_q == S_LOOKUP) && !uc_q && !flush_i;
    assign hit_inc       = lookup_cached && hit_i;
    assign miss_inc      = lookup_cached && !hit_i;

    dcache_perf_cnt u_perf_hit (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (hit_inc),
        .cnt_o (perf_hit_o)
    );

    dcache_perf_cnt u_perf_miss (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (miss_inc),
        .cnt_o (perf_miss_o)
    );
`else
    assign perf_hit_o  = '0;
    assign perf_miss_o = '0;
`endif

endmodule

// File: tb/tb_dcache_rbuf_ctrl.sv
// Directed bench for dcache_rbuf_ctrl: per-cycle expected outputs are queued
// by the stimulus and compared by an independent negedge monitor.
module tb_dcache_rbuf_ctrl;

    typedef struct packed {
        logic [7:0]  o;    // rr, we, rv, busy, rd, rdu, wr, rf
        logic [1:0]  idx;
        logic [31:0] ph;
        logic [31:0] pm;
    } exp_t;

    localparam logic [9:0] RV = 10'h200, ST = 10'h100, UC = 10'h080, FL = 10'h040,
                           HIT = 10'h020, VD = 10'h010, RDR = 10'h008, RET = 10'h004,
                           LAST = 10'h002, WRR = 10'h001;
    localparam logic [7:0] O_RR = 8'h80, O_WE = 8'h40, O_RV = 8'h20, O_BSY = 8'h10,
                           O_RD = 8'h08, O_RDU = 8'h04, O_WR = 8'h02, O_RF = 8'h01;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_store, req_uncached, flush, hit, victim_dirty;
    logic        mem_rd_ready, mem_ret_valid, mem_ret_last, mem_wr_ready;
    logic        req_ready, rbuf_we, mem_rd_req, mem_rd_uncached, mem_wr_req;
    logic        refill_we, resp_valid, busy;
    logic [1:0]  refill_idx;
    logic [31:0] perf_hit, perf_miss;

    logic [31:0] ph, pm;
    exp_t        exp_q[$];
    int          tag_q[$];
    int          step = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    dcache_rbuf_ctrl #(.LINE_WORDS(4)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_store_i       (req_store),
        .req_uncached_i    (req_uncached),
        .flush_i           (flush),
        .rbuf_we_o         (rbuf_we),
        .hit_i             (hit),
        .victim_dirty_i    (victim_dirty),
        .mem_rd_req_o      (mem_rd_req),
        .mem_rd_ready_i    (mem_rd_ready),
        .mem_rd_uncached_o (mem_rd_uncached),
        .mem_ret_valid_i   (mem_ret_valid),
        .mem_ret_last_i    (mem_ret_last),
        .mem_wr_req_o      (mem_wr_req),
        .mem_wr_ready_i    (mem_wr_ready),
        .refill_we_o       (refill_we),
        .refill_idx_o      (refill_idx),
        .resp_valid_o      (resp_valid),
        .busy_o            (busy),
        .perf_hit_o        (perf_hit),
        .perf_miss_o       (perf_miss)
    );

    // Monitor: compares every cycle for which the stimulus queued an expectation.
    always @(negedge clk) begin
        exp_t e, a;
        int   t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a.o   = {req_ready, rbuf_we, resp_valid, busy,
                     mem_rd_req, mem_rd_uncached, mem_wr_req, refill_we};
            a.idx = refill_idx;
            a.ph  = perf_hit;
            a.pm  = perf_miss;
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL step%0d: got rr/we/rv/bsy/rd/rdu/wr/rf=%b idx=%0d ph=%0d pm=%0d, expected %b idx=%0d ph=%0d pm=%0d",
                         t, a.o, a.idx, a.ph, a.pm, e.o, e.idx, e.ph, e.pm);
            end
        end
    end

    task automatic cyc(input logic [9:0] in, input logic [7:0] o, input int idx, input bit chk);
        exp_t e;
        {req_valid, req_store, req_uncached, flush, hit, victim_dirty,
         mem_rd_ready, mem_ret_valid, mem_ret_last, mem_wr_ready} = in;
        if (chk) begin
            e.o   = o;
            e.idx = idx[1:0];
            e.ph  = ph;
            e.pm  = pm;
            exp_q.push_back(e);
            tag_q.push_back(step);
        end
        step++;
        @(posedge clk);
        #1;
    endtask

    task automatic bump_h();
`ifdef DCACHE_PERF_EN
        ph = ph + 1;
`endif
    endtask

    task automatic bump_m();
`ifdef DCACHE_PERF_EN
        pm = pm + 1;
`endif
    endtask

    initial begin
        rst = 1'b1;
        {req_valid, req_store, req_uncached, flush, hit, victim_dirty,
         mem_rd_ready, mem_ret_valid, mem_ret_last, mem_wr_ready} = '0;
        ph = '0;
        pm = '0;
        @(posedge clk);
        #1;
        cyc(10'h0, O_RR, 0, 1);                 // reset state
        rst = 1'b0;

        // single load hit
        cyc(RV,  O_RR | O_WE, 0, 1);
        cyc(HIT, O_RR | O_RV | O_BSY, 0, 1); bump_h();
        cyc(10'h0, O_RR, 0, 1);

        // three back-to-back hits
        cyc(RV,       O_RR | O_WE, 0, 1);
        cyc(RV | HIT, O_RR | O_WE | O_RV | O_BSY, 0, 1); bump_h();
        cyc(RV | HIT, O_RR | O_WE | O_RV | O_BSY, 0, 1); bump_h();
        cyc(HIT,      O_RR | O_RV | O_BSY, 0, 1);        bump_h();
        cyc(10'h0,    O_RR, 0, 1);

        // clean miss, read ready after two wait cycles
        cyc(RV,         O_RR | O_WE, 0, 1);
        cyc(10'h0,      O_BSY, 0, 1); bump_m();
        cyc(10'h0,      O_BSY | O_RD, 0, 1);
        cyc(10'h0,      O_BSY | O_RD, 0, 1);
        cyc(RDR,        O_BSY | O_RD, 0, 1);
        cyc(RET,        O_BSY | O_RF, 0, 1);
        cyc(RET,        O_BSY | O_RF, 1, 1);
        cyc(RET,        O_BSY | O_RF, 2, 1);
        cyc(RET | LAST, O_BSY | O_RF, 3, 1);
        cyc(10'h0,      O_RV | O_BSY, 0, 1);
        cyc(10'h0,      O_RR, 0, 1);

        // dirty store miss; stray return beat and flush during writeback ignored
        cyc(RV | ST,    O_RR | O_WE, 0, 1);
        cyc(VD,         O_BSY, 0, 1); bump_m();
        cyc(RET,        O_BSY | O_WR, 0, 1);
        cyc(FL,         O_BSY | O_WR, 0, 1);
        cyc(WRR,        O_BSY | O_WR, 0, 1);
        cyc(RDR,        O_BSY | O_RD, 0, 1);
        cyc(RET,        O_BSY | O_RF, 0, 1);
        cyc(RET | FL,   O_BSY | O_RF, 1, 1);
        cyc(RET,        O_BSY | O_RF, 2, 1);
        cyc(RET | LAST, O_BSY | O_RF, 3, 1);
        cyc(10'h0,      O_RV | O_BSY, 0, 1);
        cyc(10'h0,      O_RR, 0, 1);

        // flush in lookup on a miss and on a hit; flush blocks capture in idle
        cyc(RV,        O_RR | O_WE, 0, 1);
        cyc(FL,        O_BSY, 0, 1);
        cyc(RV | FL,   8'h00, 0, 1);
        cyc(10'h0,     O_RR, 0, 1);
        cyc(RV,        O_RR | O_WE, 0, 1);
        cyc(FL | HIT,  O_BSY, 0, 1);
        cyc(10'h0,     O_RR, 0, 1);

        // uncached load: single beat, no array write, counter moves to 1
        cyc(RV | UC,   O_RR | O_WE, 0, 1);
        cyc(RV | HIT,  O_BSY, 0, 1);
        cyc(RDR,       O_BSY | O_RD | O_RDU, 0, 1);
        cyc(RET | LAST, O_BSY, 0, 1);
        cyc(10'h0,     O_RV | O_BSY, 1, 1);
        cyc(10'h0,     O_RR, 1, 1);

        // uncached store
        cyc(RV | UC | ST, O_RR | O_WE, 1, 1);
        cyc(10'h0,        O_BSY, 1, 1);
        cyc(10'h0,        O_BSY | O_WR, 1, 1);
        cyc(WRR,          O_BSY | O_WR, 1, 1);
        cyc(10'h0,        O_RV | O_BSY, 1, 1);
        cyc(10'h0,        O_RR, 1, 1);

        // reset asserted on refill beat 2
        cyc(RV,    O_RR | O_WE, 1, 1);
        cyc(10'h0, O_BSY, 1, 1); bump_m();
        cyc(RDR,   O_BSY | O_RD, 1, 1);
        cyc(RET,   O_BSY | O_RF, 0, 1);
        cyc(RET,   O_BSY | O_RF, 1, 1);
        rst = 1'b1;
        cyc(RET, 8'h00, 0, 0);
        ph = '0;
        pm = '0;
        cyc(RET | LAST, O_RR, 0, 1);
        rst = 1'b0;
        cyc(RV,    O_RR | O_WE, 0, 1);
        cyc(HIT,   O_RR | O_RV | O_BSY, 0, 1); bump_h();
        cyc(10'h0, O_RR, 0, 1);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
